vector_xing_arb: RTL and testbench
==================================

Name: vector_xing_arb

Overview:
- Single-clock, N-channel front end for the clock-crossing path.
- Each channel has a one-entry mailbox; a round-robin arbiter forwards one (channel, data) pair at a time to a single push/ready consumer, normally an existing vector crossing whose iready throttles it.
- Gives several register producers in one domain shared use of one crossing.
- Adds two behaviours the single-vector crossing lacks: optional coalescing of stale updates, and channel tagging.

Parameters:
- DATA_WIDTH, 32, width of each channel's vector.
- NUM_CHANNELS, 4, number of producer channels (2..16).
- COALESCE, 1:
  - 1: a push to a pending mailbox overwrites it; ch_ready is always high outside reset.
  - 0: ch_ready is low while the mailbox is pending.
- CHAN_WIDTH (localparam) = max(1, $clog2(NUM_CHANNELS)).

Ports:
- iclk  in  1  clock for every signal.
- ireset  in  1  reset; synchronous and active-high.
- ch_data  in  NUM_CHANNELS*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- ch_push  in  NUM_CHANNELS  per-channel push, qualified by ch_ready.
- ch_ready  out  NUM_CHANNELS  per-channel holdoff.
- out_data  out  DATA_WIDTH  forwarded vector.
- out_chan  out  CHAN_WIDTH  source channel of out_data.
- out_push  out  1  out_data/out_chan valid.
- out_ready  in  1  consumer accepts when out_push && out_ready.

Behaviour:
- Reset (ireset high at a posedge):
  - pending=0, mailboxes=0, out_push=0, out_data=0, out_chan=0, last_grant=NUM_CHANNELS-1, state=IDLE.
  - ch_ready is combinationally 0 while ireset is high; pushes in that cycle are ignored.
- Mailbox write: ch_push[c] && ch_ready[c] latches data and sets pending[c] on the next edge.
- Coalescing (COALESCE=1): a push to a pending mailbox replaces its data, so only the newest value is forwarded. The overwrite counts as a drop.
- State machine (2 states):
  - IDLE: if any pending, pick winner g, load out_data/out_chan from mailbox g, clear pending[g], set out_push, go to OFFER.
  - OFFER: out_push, out_data and out_chan are held stable until out_ready.
    - On accept with any pending: grant again in the same edge and stay in OFFER, giving back-to-back transfers.
    - On accept with none pending: clear out_push and go to IDLE.
- Round-robin:
  - Search starts at last_grant+1, wrapping from NUM_CHANNELS-1 to 0.
  - last_grant updates on each grant.
  - No channel waits more than NUM_CHANNELS grants.
- Simultaneous push and grant on the same channel (COALESCE=1): the old data is forwarded, the new data is stored, and pending stays 1.
- Latency: push at edge k gives pending at k+1; if idle, out_push rises at k+2.
- Throughput: one transfer per cycle while out_ready is held high.
- Reset mid-OFFER: out_push drops at that edge and the in-flight vector is lost. The consumer sees no handshake.
- out_ready while out_push is low: ignored.

Optional Feature:
- VECTOR_XING_ARB_DROP_CNT_EN defined:
  - Adds output drop_cnt (NUM_CHANNELS*16 bits): per-channel 16-bit saturating count of coalesce overwrites.
  - Saturates at 16'hFFFF; cleared by reset.
  - Always 0 when COALESCE=0.
- Undefined: port and counters absent; behaviour otherwise identical.

Decomposition:
- Package vector_xing_pkg: state enum type (IDLE, OFFER) and drop counter width constant DROP_CNT_WIDTH=16.
- Sub-module rr_pick: combinational round-robin priority pick.
  - Inputs: request vector, last grant index.
  - Outputs: grant index, any-request flag.
  - Reusable by other multi-source arbiters.

Test Plan:
- Single push: ch 2 pushes 32'hDEADBEEF with out_ready=1 -> out_push at +2 cycles, out_chan=2, out_data=32'hDEADBEEF, one beat only.
- Fairness: all 4 channels push in the same cycle with out_ready=1 -> beats out_chan 0,1,2,3 on consecutive cycles, each with its own data.
- Backpressure: out_ready=0 for 10 cycles while offering ch 1 -> out_data/out_chan/out_push stable all 10 cycles; accepted exactly once when out_ready rises.
- Coalesce: during a stall, ch 0 pushes 1, 2, 3 -> one beat with data 3 after the stall. With VECTOR_XING_ARB_DROP_CNT_EN, drop_cnt[0]=2.
- COALESCE=0: ch 3 pushes while pending -> ch_ready[3]=0; the push is ignored; the original data is delivered; ch_ready[3] returns to 1 after the grant.
- Reset mid-OFFER: ireset pulses for 1 cycle while offering -> out_push=0 next cycle, pending cleared, no beat emitted afterwards.

Source files
------------

// File: rtl/vector_xing_pkg.sv
// Shared types for the vector crossing arbiter: FSM state encoding and
// drop-counter width, plus the channel-index width helper.
package vector_xing_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int DROP_CNT_WIDTH = 16;

    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vector_xing_arb_rr_pick.sv
// Combinational round-robin pick: first requester after 'last', wrapping,
// so the most recent winner has the lowest priority.
module rr_pick
    import vector_xing_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = chan_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] last,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 any
);

    logic [IDX_WIDTH-1:0] idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_WIDTH'((int'(last) + i) % NUM_REQ);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_xing_arb.sv
// N-channel mailbox front end with round-robin forwarding into one push/ready crossing.
// Define VECTOR_XING_ARB_DROP_CNT_EN to add per-channel coalesce drop counters (drop_cnt).
module vector_xing_arb
    import vector_xing_pkg::*;
#(
    parameter int   DATA_WIDTH   = 32,
    parameter int   NUM_CHANNELS = 4,
    parameter int   COALESCE     = 1,
    localparam int  CHAN_WIDTH   = chan_width(NUM_CHANNELS)
) (
    input  logic                               iclk,
    input  logic                               ireset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]            ch_push,
    output logic [NUM_CHANNELS-1:0]            ch_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CHAN_WIDTH-1:0]              out_chan,
    output logic                               out_push,
    input  logic                               out_ready
`ifdef VECTOR_XING_ARB_DROP_CNT_EN
    ,
    output logic [NUM_CHANNELS*DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    state_t                  state, state_next;
    logic [NUM_CHANNELS-1:0] pending;
    logic [DATA_WIDTH-1:0]   mbox [NUM_CHANNELS];
    logic [CHAN_WIDTH-1:0]   last_grant;
    logic [CHAN_WIDTH-1:0]   pick;
    logic                    pick_any;
    logic                    grant_en;
    logic [NUM_CHANNELS-1:0] wr_en;
    logic [NUM_CHANNELS-1:0] grant_vec;

    // With coalescing a pending mailbox still accepts; its old value is simply replaced.
    assign ch_ready  = ireset ? '0 : ((COALESCE != 0) ? '1 : ~pending);
    assign wr_en     = ch_push & ch_ready;
    assign grant_vec = grant_en ? (NUM_CHANNELS'(1) << pick) : '0;
    assign out_push  = (state == OFFER);

    rr_pick #(
        .NUM_REQ   (NUM_CHANNELS),
        .IDX_WIDTH (CHAN_WIDTH)
    ) u_pick (
        .req   (pending),
        .last  (last_grant),
        .grant (pick),
        .any   (pick_any)
    );

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_en   = 1'b1;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    if (pick_any) grant_en   = 1'b1;
                    else          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (ireset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            pending    <= '0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CHAN_WIDTH'(NUM_CHANNELS - 1);
            // NOTE: mailboxes are reset too, so nothing stale can be forwarded after reset.
            for (int c = 0; c < NUM_CHANNELS; c++) mbox[c] <= '0;
        end else begin
            // A same-edge push and grant on one channel keeps it pending with the new value.
            pending <= (pending & ~grant_vec) | wr_en;
            if (grant_en) begin
                out_data   <= mbox[pick];
                out_chan   <= pick;
                last_grant <= pick;
            end
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wr_en[c]) mbox[c] <= ch_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef VECTOR_XING_ARB_DROP_CNT_EN
    logic [NUM_CHANNELS-1:0] drop_ev;

    // Overwriting a value that is being forwarded on this same edge loses nothing.
    assign drop_ev = (COALESCE != 0) ? (wr_en & pending & ~grant_vec) : '0;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            drop_cnt <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (drop_ev[c] && (drop_cnt[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] != '1))
                    drop_cnt[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] <=
                        drop_cnt[c*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] + DROP_CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vector_xing_arb.sv
// Bench for vector_xing_arb: a coalescing and a non-coalescing instance share stimulus
// and are compared every cycle against a transaction-level mailbox/round-robin model.
module tb_vector_xing_arb;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int CW  = 2;
    localparam int DCW = 16;

    logic            iclk      = 1'b0;
    logic            ireset    = 1'b1;
    logic [N*DW-1:0] ch_data   = '0;
    logic [N-1:0]    ch_push   = '0;
    logic            out_ready = 1'b0;

    logic [N-1:0]  rdy   [2];
    logic [DW-1:0] odat  [2];
    logic [CW-1:0] ochn  [2];
    logic          opush [2];
`ifdef VECTOR_XING_ARB_DROP_CNT_EN
    logic [N*DCW-1:0] dcnt [2];
`endif

    always #5 iclk = ~iclk;

    vector_xing_arb #(.DATA_WIDTH(DW), .NUM_CHANNELS(N), .COALESCE(1)) u_dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .ch_data   (ch_data),
        .ch_push   (ch_push),
        .ch_ready  (rdy[0]),
        .out_data  (odat[0]),
        .out_chan  (ochn[0]),
        .out_push  (opush[0]),
        .out_ready (out_ready)
`ifdef VECTOR_XING_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (dcnt[0])
`endif
    );

    vector_xing_arb #(.DATA_WIDTH(DW), .NUM_CHANNELS(N), .COALESCE(0)) u_dut_nc (
        .iclk      (iclk),
        .ireset    (ireset),
        .ch_data   (ch_data),
        .ch_push   (ch_push),
        .ch_ready  (rdy[1]),
        .out_data  (odat[1]),
        .out_chan  (ochn[1]),
        .out_push  (opush[1]),
        .out_ready (out_ready)
`ifdef VECTOR_XING_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (dcnt[1])
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    typedef struct {
        int            chan;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    beat_t beats0[$];
    beat_t beats1[$];

    // Model state: per-instance mailboxes plus the single offered beat.
    bit            m_coal  [2] = '{1'b1, 1'b0};
    bit            m_pend  [2][N];
    logic [DW-1:0] m_val   [2][N];
    bit            m_valid [2];
    logic [DW-1:0] m_odata [2];
    int            m_ochan [2];
    int            m_last  [2] = '{N-1, N-1};
    int            m_drop  [2][N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready(input int d, input int c);
        if (ireset) return 1'b0;
        return m_coal[d] ? 1'b1 : !m_pend[d][c];
    endfunction

    task automatic model_step(input int d);
        bit    old_pend [N];
        bit    acc;
        int    g;
        beat_t b;
        if (ireset) begin
            for (int c = 0; c < N; c++) begin
                m_pend[d][c] = 1'b0;
                m_val[d][c]  = '0;
                m_drop[d][c] = 0;
            end
            m_valid[d] = 1'b0;
            m_odata[d] = '0;
            m_ochan[d] = 0;
            m_last[d]  = N - 1;
            return;
        end
        for (int c = 0; c < N; c++) old_pend[c] = m_pend[d][c];
        acc = m_valid[d] && out_ready;
        if (acc) begin
            b.chan = m_ochan[d];
            b.data = m_odata[d];
            b.cyc  = cyc;
            if (d == 0) beats0.push_back(b);
            else        beats1.push_back(b);
        end
        g = -1;
        if (!m_valid[d] || acc) begin
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_last[d] + i) % N;
                if (old_pend[c]) begin
                    g = c;
                    break;
                end
            end
            if (g >= 0) begin
                m_valid[d]    = 1'b1;
                m_odata[d]    = m_val[d][g];
                m_ochan[d]    = g;
                m_pend[d][g]  = 1'b0;
                m_last[d]     = g;
            end else begin
                m_valid[d] = 1'b0;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (ch_push[c] && (m_coal[d] || !old_pend[c])) begin
                if (old_pend[c] && c != g && m_drop[d][c] < 65535) m_drop[d][c]++;
                m_val[d][c]  = ch_data[c*DW +: DW];
                m_pend[d][c] = 1'b1;
            end
        end
    endtask

    always @(posedge iclk) begin
        cyc++;
        model_step(0);
        model_step(1);
    end

    always @(negedge iclk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < N; c++)
                check($sformatf("d%0d_ch_ready%0d", d, c), 64'(rdy[d][c]), 64'(m_ready(d, c)));
            check($sformatf("d%0d_out_push", d), 64'(opush[d]), 64'(m_valid[d]));
            if (m_valid[d]) begin
                check($sformatf("d%0d_out_chan", d), 64'(ochn[d]), 64'(m_ochan[d]));
                check($sformatf("d%0d_out_data", d), 64'(odat[d]), 64'(m_odata[d]));
            end
`ifdef VECTOR_XING_ARB_DROP_CNT_EN
            for (int c = 0; c < N; c++)
                check($sformatf("d%0d_drop_cnt%0d", d, c), 64'(dcnt[d][c*DCW +: DCW]), 64'(m_drop[d][c]));
`endif
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic set_data(input int c, input logic [DW-1:0] v);
        ch_data[c*DW +: DW] = v;
    endtask

    task automatic pulse_reset();
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
    endtask

    logic [DW-1:0] held_data;

    initial begin
        repeat (3) tick();
        ireset = 1'b0;
        tick();

        // Single push on ch 2: visible two cycles after it is presented, one beat only.
        beats0.delete();
        set_data(2, 32'hDEADBEEF);
        ch_push   = 4'b0100;
        out_ready = 1'b1;
        tick();
        ch_push = '0;
        check("single_not_yet", 64'(opush[0]), 64'd0);
        tick();
        check("single_push", 64'(opush[0]), 64'd1);
        check("single_chan", 64'(ochn[0]), 64'd2);
        check("single_data", 64'(odat[0]), 64'hDEADBEEF);
        tick();
        check("single_drop", 64'(opush[0]), 64'd0);
        check("single_beats", 64'(beats0.size()), 64'd1);

        // Fairness: all four push at once right after reset -> ch 0,1,2,3 back to back.
        pulse_reset();
        beats0.delete();
        for (int c = 0; c < N; c++) set_data(c, 32'hA000_0000 + 32'(c));
        ch_push = '1;
        tick();
        ch_push = '0;
        repeat (6) tick();
        check("fair_beats", 64'(beats0.size()), 64'd4);
        for (int i = 0; i < N && i < beats0.size(); i++) begin
            check($sformatf("fair_chan%0d", i), 64'(beats0[i].chan), 64'(i));
            check($sformatf("fair_data%0d", i), 64'(beats0[i].data), 64'(32'hA000_0000 + 32'(i)));
            if (i > 0)
                check($sformatf("fair_gap%0d", i), 64'(beats0[i].cyc - beats0[i-1].cyc), 64'd1);
        end

        // Backpressure: ch 1 held for 10 stalled cycles, accepted exactly once.
        beats0.delete();
        out_ready = 1'b0;
        set_data(1, 32'h1111_0001);
        ch_push = 4'b0010;
        tick();
        ch_push = '0;
        tick();
        held_data = 32'h1111_0001;
        for (int i = 0; i < 10; i++) begin
            check("bp_push", 64'(opush[0]), 64'd1);
            check("bp_chan", 64'(ochn[0]), 64'd1);
            check("bp_data", 64'(odat[0]), 64'(held_data));
            tick();
        end
        check("bp_none_yet", 64'(beats0.size()), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_once", 64'(beats0.size()), 64'd1);
        check("bp_released", 64'(opush[0]), 64'd0);

        // Coalesce: ch 0 pushes 1,2,3 behind a stalled ch 1 -> only 3 is forwarded.
        pulse_reset();
        beats0.delete();
        beats1.delete();
        out_ready = 1'b0;
        set_data(1, 32'h2222_0001);
        ch_push = 4'b0010;
        tick();
        ch_push = '0;
        tick();
        for (int v = 1; v <= 3; v++) begin
            set_data(0, 32'(v));
            ch_push = 4'b0001;
            tick();
        end
        ch_push = '0;
        tick();
        out_ready = 1'b1;
        repeat (4) tick();
        check("coal_beats", 64'(beats0.size()), 64'd2);
        if (beats0.size() == 2) begin
            check("coal_chan", 64'(beats0[1].chan), 64'd0);
            check("coal_data", 64'(beats0[1].data), 64'd3);
        end
        check("nocoal_keeps_first", 64'(beats1.size() == 2 ? beats1[1].data : '1), 64'd1);
`ifdef VECTOR_XING_ARB_DROP_CNT_EN
        check("coal_drop_cnt0", 64'(dcnt[0][DCW-1:0]), 64'd2);
`endif

        // COALESCE=0: a push to a pending ch 3 is refused; original data delivered.
        pulse_reset();
        beats1.delete();
        out_ready = 1'b0;
        set_data(3, 32'h3333_000A);
        ch_push = 4'b1000;
        tick();
        check("nc_ready_low", 64'(rdy[1][3]), 64'd0);
        set_data(3, 32'h3333_000B);
        tick();
        ch_push = '0;
        check("nc_ready_back", 64'(rdy[1][3]), 64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check("nc_beats", 64'(beats1.size()), 64'd1);
        if (beats1.size() == 1) begin
            check("nc_chan", 64'(beats1[0].chan), 64'd3);
            check("nc_data", 64'(beats1[0].data), 64'h3333_000A);
        end

        // Reset mid-OFFER: the in-flight vector is lost, nothing emerges afterwards.
        repeat (3) tick();
        beats0.delete();
        out_ready = 1'b0;
        set_data(2, 32'h4444_0002);
        ch_push = 4'b0100;
        tick();
        ch_push = '0;
        tick();
        check("rst_offering", 64'(opush[0]), 64'd1);
        pulse_reset();
        check("rst_push_low", 64'(opush[0]), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_quiet", 64'(opush[0]), 64'd0);
        end
        check("rst_no_beat", 64'(beats0.size()), 64'd0);

        // Random traffic with occasional resets; the compare process does the checking.
        repeat (3000) begin
            ch_push = N'($urandom);
            for (int c = 0; c < N; c++) set_data(c, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            ireset    = ($urandom_range(0, 299) == 0);
            tick();
        end
        ireset    = 1'b0;
        ch_push   = '0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
